// File: rtl/uart_pkg.sv
// uart_pkg: register map indices, interrupt bit positions and reset values shared by the UART CSR bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    // Word indices of the CSR map.
    localparam int IDX_CTRL       = 0;
    localparam int IDX_STATUS     = 1;
    localparam int IDX_TX_DATA    = 2;
    localparam int IDX_RX_DATA    = 3;
    localparam int IDX_BAUD_DIV   = 4;
    localparam int IDX_INT_ENABLE = 5;
    localparam int IDX_INT_STATUS = 6;
    localparam int IDX_FIFO_CTRL  = 7;
    localparam int IDX_RX_TIMEOUT = 8;
    localparam int REG_NUM        = 9;

    // Interrupt vector width and bit positions.
    localparam int INT_W = 6;

    typedef enum logic [2:0] {
        INT_TX_LOW   = 3'd0,
        INT_RX_HIGH  = 3'd1,
        INT_FRAME    = 3'd2,
        INT_OVERRUN  = 3'd3,
        INT_TX_DROP  = 3'd4,
        INT_RX_TMO   = 3'd5
    } int_bit_e;

    // Reset values.
    localparam logic [1:0]       CTRL_RST       = 2'b00;
    localparam int               BAUD_DIV_RST   = 4;
    localparam logic [INT_W-1:0] INT_EN_RST     = '0;
    localparam logic [INT_W-1:0] INT_STATUS_RST = '0;
    localparam int               TX_WM_RST      = 0;
    localparam int               RX_WM_RST      = 1;
    localparam int               RX_TIMEOUT_RST = 0;

endpackage

// File: rtl/uart_rx_timeout.sv
// uart_rx_timeout: counts RX bit periods while the RX FIFO holds data and nothing moves; one-shot flag at threshold.
// Latency: o_set is combinational from the count; it is high for one cycle per idle period.
// Backpressure: none; i_clear restarts the count and re-arms the one-shot.
// Ports: i_threshold (0 disables), i_clear (idle period ends), i_tick (one per bit period), o_set (interrupt set pulse).
module uart_rx_timeout #(
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [TIMEOUT_WIDTH-1:0] i_threshold,
    input  logic                     i_clear,
    input  logic                     i_tick,
    output logic                     o_set
);

    logic [TIMEOUT_WIDTH-1:0] r_count;
    logic                     r_fired;
    logic                     w_hit;

    // Compare with >= so that lowering the threshold below the current count still fires.
    assign w_hit = (i_threshold != '0) && (r_count >= i_threshold);
    assign o_set = w_hit & ~r_fired & ~i_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_fired <= 1'b0;
        end else if (i_clear) begin
            r_count <= '0;
            r_fired <= 1'b0;
        end else begin
            // Saturate at the threshold.
            if (i_tick && (r_count < i_threshold)) begin
                r_count <= r_count + 1'b1;
            end
            if (w_hit) begin
                r_fired <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_csr_bank.sv
// uart_csr_bank: CSR bank between the AXI-lite register slave and the UART TX/RX/FIFO/baud datapath.
// Latency: reads combinational while reg_ren is high; writes land on the next clk; FIFO reset pulses one cycle after the write.
// Backpressure: none on the register port; a TX_DATA write while disabled or full is dropped and raises INT[4].
// Optional: define UART_RX_TIMEOUT_EN to add the RX_TIMEOUT register (index 8) and the INT[5] character timeout.
// Ports: reg_* register slave side; tx_*/rx_* FIFO side; frame/overrun error pulses; baud_*, *_fifo_reset, irq to datapath.
// FIFO level fields sit in single byte lanes, so LVL_W must not exceed 8.
module uart_csr_bank
    import uart_pkg::*;
#(
    parameter  int DATA_WIDTH     = 32,
    parameter  int REG_ADDR_WIDTH = 4,
    parameter  int BAUD_DIV_WIDTH = 16,
    parameter  int FIFO_DEPTH     = 16,
    parameter  int TIMEOUT_WIDTH  = 8,
    localparam int LVL_W          = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] reg_addr,
    input  logic [DATA_WIDTH-1:0]     reg_wdata,
    input  logic [DATA_WIDTH/8-1:0]   reg_wstrb,
    input  logic                      reg_wen,
    input  logic                      reg_ren,
    output logic [DATA_WIDTH-1:0]     reg_rdata,
    output logic                      reg_error,
    output logic [7:0]                tx_wr_data,
    output logic                      tx_wr_en,
    input  logic                      tx_empty,
    input  logic                      tx_full,
    input  logic                      tx_active,
    input  logic [LVL_W-1:0]          tx_level,
    input  logic [7:0]                rx_rd_data,
    output logic                      rx_rd_en,
    input  logic                      rx_empty,
    input  logic                      rx_full,
    input  logic                      rx_active,
    input  logic [LVL_W-1:0]          rx_level,
    input  logic                      rx_push,
    input  logic                      rx_bit_tick,
    input  logic                      frame_error,
    input  logic                      overrun_error,
    output logic [BAUD_DIV_WIDTH-1:0] baud_divisor,
    output logic                      baud_enable,
    output logic                      tx_fifo_reset,
    output logic                      rx_fifo_reset,
    output logic                      irq
);

`ifdef UART_RX_TIMEOUT_EN
    localparam logic [INT_W-1:0] INT_MASK = 6'h3F;
`else
    localparam logic [INT_W-1:0] INT_MASK = 6'h1F;
`endif

    // Registers.
    logic [1:0]                r_ctrl;
    logic [BAUD_DIV_WIDTH-1:0] r_baud;
    logic [INT_W-1:0]          r_int_en;
    logic [INT_W-1:0]          r_int_status;
    logic [LVL_W-1:0]          r_tx_wm;
    logic [LVL_W-1:0]          r_rx_wm;
    logic                      r_frm_sticky;
    logic                      r_ovr_sticky;
    logic                      r_tx_low_q;
    logic                      r_rx_high_q;
    logic                      r_tx_fifo_reset;
    logic                      r_rx_fifo_reset;

    // Decode and byte-lane mask.
    logic [REG_NUM-1:0]        w_sel;
    logic [DATA_WIDTH-1:0]     w_bmask;
    logic                      w_wr_ctrl, w_wr_baud, w_wr_inten, w_wr_fctl;
    logic [1:0]                w_ctrl_nxt;
    logic [BAUD_DIV_WIDTH-1:0] w_baud_mrg;
    logic [INT_W-1:0]          w_inten_nxt;
    logic [LVL_W-1:0]          w_txwm_nxt, w_rxwm_nxt;
    logic                      w_tx_push_req, w_tx_drop;
    logic                      w_tx_low, w_rx_high, w_tmo_set;
    logic [INT_W-1:0]          w_int_set, w_int_clr;
    logic [DATA_WIDTH-1:0]     w_rdata;
    logic                      w_unused;

    always_comb begin
        for (int i = 0; i < REG_NUM; i++) begin
            w_sel[i] = (reg_addr == REG_ADDR_WIDTH'(i));
        end
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
            w_bmask[b*8 +: 8] = {8{reg_wstrb[b]}};
        end
    end

    assign w_wr_ctrl  = reg_wen & w_sel[IDX_CTRL];
    assign w_wr_baud  = reg_wen & w_sel[IDX_BAUD_DIV];
    assign w_wr_inten = reg_wen & w_sel[IDX_INT_ENABLE];
    assign w_wr_fctl  = reg_wen & w_sel[IDX_FIFO_CTRL];

    // Byte-lane merges: only lanes with a strobe take the write data.
    assign w_ctrl_nxt  = (r_ctrl & ~w_bmask[1:0]) | (reg_wdata[1:0] & w_bmask[1:0]);
    assign w_baud_mrg  = (r_baud & ~w_bmask[BAUD_DIV_WIDTH-1:0])
                       | (reg_wdata[BAUD_DIV_WIDTH-1:0] & w_bmask[BAUD_DIV_WIDTH-1:0]);
    assign w_inten_nxt = ((r_int_en & ~w_bmask[INT_W-1:0])
                       | (reg_wdata[INT_W-1:0] & w_bmask[INT_W-1:0])) & INT_MASK;
    assign w_txwm_nxt  = (r_tx_wm & ~w_bmask[8 +: LVL_W]) | (reg_wdata[8 +: LVL_W] & w_bmask[8 +: LVL_W]);
    assign w_rxwm_nxt  = (r_rx_wm & ~w_bmask[16 +: LVL_W]) | (reg_wdata[16 +: LVL_W] & w_bmask[16 +: LVL_W]);

    // TX push / RX pop.
    assign w_tx_push_req = reg_wen & w_sel[IDX_TX_DATA] & reg_wstrb[0];
    assign tx_wr_en      = w_tx_push_req & r_ctrl[0] & ~tx_full;
    assign w_tx_drop     = w_tx_push_req & ~tx_wr_en;
    assign tx_wr_data    = reg_wdata[7:0];
    assign rx_rd_en      = reg_ren & w_sel[IDX_RX_DATA] & r_ctrl[1] & ~rx_empty;

    // Watermark conditions use the stored watermark, so a watermark write is seen the cycle after.
    assign w_tx_low  = (tx_level <= r_tx_wm);
    assign w_rx_high = (rx_level >= r_rx_wm);

`ifdef UART_RX_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] r_rx_timeout;
    logic [TIMEOUT_WIDTH-1:0] w_tmo_nxt;
    logic                     w_tmo_clear;

    assign w_tmo_nxt   = (r_rx_timeout & ~w_bmask[TIMEOUT_WIDTH-1:0])
                       | (reg_wdata[TIMEOUT_WIDTH-1:0] & w_bmask[TIMEOUT_WIDTH-1:0]);
    assign w_tmo_clear = rx_push | rx_rd_en | rx_empty | ~r_ctrl[1] | r_rx_fifo_reset;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_timeout <= TIMEOUT_WIDTH'(RX_TIMEOUT_RST);
        end else if (reg_wen && w_sel[IDX_RX_TIMEOUT]) begin
            r_rx_timeout <= w_tmo_nxt;
        end
    end

    uart_rx_timeout #(
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) u_rx_timeout (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_threshold (r_rx_timeout),
        .i_clear     (w_tmo_clear),
        .i_tick      (rx_bit_tick),
        .o_set       (w_tmo_set)
    );
`else
    assign w_tmo_set = 1'b0;
`endif

    always_comb begin
        w_int_set              = '0;
        w_int_set[INT_TX_LOW]  = w_tx_low & ~r_tx_low_q;
        w_int_set[INT_RX_HIGH] = w_rx_high & ~r_rx_high_q;
        w_int_set[INT_FRAME]   = frame_error;
        w_int_set[INT_OVERRUN] = overrun_error;
        w_int_set[INT_TX_DROP] = w_tx_drop;
        w_int_set[INT_RX_TMO]  = w_tmo_set;
    end

    assign w_int_clr = (reg_wen & w_sel[IDX_INT_STATUS] & reg_wstrb[0]) ? reg_wdata[INT_W-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl          <= CTRL_RST;
            r_baud          <= BAUD_DIV_WIDTH'(BAUD_DIV_RST);
            r_int_en        <= INT_EN_RST;
            r_int_status    <= INT_STATUS_RST;
            r_tx_wm         <= LVL_W'(TX_WM_RST);
            r_rx_wm         <= LVL_W'(RX_WM_RST);
            r_frm_sticky    <= 1'b0;
            r_ovr_sticky    <= 1'b0;
            r_tx_low_q      <= 1'b0;
            r_rx_high_q     <= 1'b0;
            r_tx_fifo_reset <= 1'b0;
            r_rx_fifo_reset <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl <= w_ctrl_nxt;
            end
            // A zero divisor would stall the baud generator; store 1 instead.
            if (w_wr_baud) begin
                r_baud <= (w_baud_mrg == '0) ? BAUD_DIV_WIDTH'(1) : w_baud_mrg;
            end
            if (w_wr_inten) begin
                r_int_en <= w_inten_nxt;
            end
            if (w_wr_fctl) begin
                r_tx_wm <= w_txwm_nxt;
                r_rx_wm <= w_rxwm_nxt;
            end
            r_tx_fifo_reset <= w_wr_fctl & reg_wstrb[0] & reg_wdata[0];
            r_rx_fifo_reset <= w_wr_fctl & reg_wstrb[0] & reg_wdata[1];
            // Set has priority over a same-cycle W1C.
            r_int_status    <= ((r_int_status & ~w_int_clr) | w_int_set) & INT_MASK;
            r_frm_sticky    <= (r_frm_sticky & ~w_int_clr[INT_FRAME]) | frame_error;
            r_ovr_sticky    <= (r_ovr_sticky & ~w_int_clr[INT_OVERRUN]) | overrun_error;
            r_tx_low_q      <= w_tx_low;
            r_rx_high_q     <= w_rx_high;
        end
    end

    // Read mux.
    always_comb begin
        w_rdata = '0;
        if (reg_ren) begin
            if (w_sel[IDX_CTRL]) begin
                w_rdata = DATA_WIDTH'(r_ctrl);
            end
            if (w_sel[IDX_STATUS]) begin
                w_rdata[7:0]        = {r_ovr_sticky, r_frm_sticky, rx_active, tx_active,
                                       rx_full, rx_empty, tx_full, tx_empty};
                w_rdata[8 +: LVL_W]  = tx_level;
                w_rdata[16 +: LVL_W] = rx_level;
            end
            if (w_sel[IDX_RX_DATA] && rx_rd_en) begin
                w_rdata = DATA_WIDTH'(rx_rd_data);
            end
            if (w_sel[IDX_BAUD_DIV]) begin
                w_rdata = DATA_WIDTH'(r_baud);
            end
            if (w_sel[IDX_INT_ENABLE]) begin
                w_rdata = DATA_WIDTH'(r_int_en);
            end
            if (w_sel[IDX_INT_STATUS]) begin
                w_rdata = DATA_WIDTH'(r_int_status);
            end
            if (w_sel[IDX_FIFO_CTRL]) begin
                w_rdata[8 +: LVL_W]  = r_tx_wm;
                w_rdata[16 +: LVL_W] = r_rx_wm;
            end
`ifdef UART_RX_TIMEOUT_EN
            if (w_sel[IDX_RX_TIMEOUT]) begin
                w_rdata = DATA_WIDTH'(r_rx_timeout);
            end
`endif
        end
    end

    assign reg_rdata     = w_rdata;
    assign reg_error     = (reg_wen | reg_ren) & ~(|w_sel);
    assign baud_divisor  = r_baud;
    assign baud_enable   = |r_ctrl;
    assign tx_fifo_reset = r_tx_fifo_reset;
    assign rx_fifo_reset = r_rx_fifo_reset;
    assign irq           = |(r_int_status & r_int_en);

    // Data bits outside implemented fields, and the timeout inputs in builds without the timeout.
    assign w_unused = ^{reg_wdata, w_bmask, rx_bit_tick, rx_push};

endmodule

// File: tb/tb_uart_csr_bank.sv
module tb_uart_csr_bank;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int BW = 16;
    localparam int FD = 16;
    localparam int TW = 8;
    localparam int LW = $clog2(FD + 1);
    localparam int LMASK = (1 << LW) - 1;
`ifdef UART_RX_TIMEOUT_EN
    localparam int INTMASK = 'h3F;
    localparam bit HAS_TMO = 1'b1;
`else
    localparam int INTMASK = 'h1F;
    localparam bit HAS_TMO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] reg_addr = '0;
    logic [DW-1:0] reg_wdata = '0;
    logic [3:0]    reg_wstrb = '0;
    logic          reg_wen = 1'b0;
    logic          reg_ren = 1'b0;
    logic [DW-1:0] reg_rdata;
    logic          reg_error;
    logic [7:0]    tx_wr_data;
    logic          tx_wr_en;
    logic          tx_empty = 1'b1;
    logic          tx_full = 1'b0;
    logic          tx_active = 1'b0;
    logic [LW-1:0] tx_level = '0;
    logic [7:0]    rx_rd_data = '0;
    logic          rx_rd_en;
    logic          rx_empty = 1'b1;
    logic          rx_full = 1'b0;
    logic          rx_active = 1'b0;
    logic [LW-1:0] rx_level = '0;
    logic          rx_push = 1'b0;
    logic          rx_bit_tick = 1'b0;
    logic          frame_error = 1'b0;
    logic          overrun_error = 1'b0;
    logic [BW-1:0] baud_divisor;
    logic          baud_enable;
    logic          tx_fifo_reset;
    logic          rx_fifo_reset;
    logic          irq;

    always #5 clk = ~clk;

    uart_csr_bank #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .BAUD_DIV_WIDTH(BW),
        .FIFO_DEPTH(FD), .TIMEOUT_WIDTH(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
        .reg_wen(reg_wen), .reg_ren(reg_ren), .reg_rdata(reg_rdata), .reg_error(reg_error),
        .tx_wr_data(tx_wr_data), .tx_wr_en(tx_wr_en), .tx_empty(tx_empty), .tx_full(tx_full),
        .tx_active(tx_active), .tx_level(tx_level),
        .rx_rd_data(rx_rd_data), .rx_rd_en(rx_rd_en), .rx_empty(rx_empty), .rx_full(rx_full),
        .rx_active(rx_active), .rx_level(rx_level), .rx_push(rx_push), .rx_bit_tick(rx_bit_tick),
        .frame_error(frame_error), .overrun_error(overrun_error),
        .baud_divisor(baud_divisor), .baud_enable(baud_enable),
        .tx_fifo_reset(tx_fifo_reset), .rx_fifo_reset(rx_fifo_reset), .irq(irq)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_ctrl = 0, m_baud = 4, m_inten = 0, m_ints = 0;
    int m_txwm = 0, m_rxwm = 1, m_tmo = 0, m_idle = 0;
    bit m_frm = 0, m_ovr = 0, m_txlow_prev = 0, m_rxhigh_prev = 0;
    bit m_txrst = 0, m_rxrst = 0, m_fired = 0;
    int s_set, s_clr, s_w;
    bit s_ctx, s_crx, s_clear, s_rd;

    function automatic int lanes(input int old_v, input logic [31:0] wd, input logic [3:0] st);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return int'(r);
    endfunction

    function automatic logic [31:0] model_read(input int a);
        logic [31:0] s;
        s = '0;
        case (a)
            0: s = m_ctrl;
            1: begin
                s[7:0] = {m_ovr, m_frm, rx_active, tx_active, rx_full, rx_empty, tx_full, tx_empty};
                s[8 +: LW] = tx_level;
                s[16 +: LW] = rx_level;
            end
            3: if (m_ctrl[1] && !rx_empty) s = {24'h0, rx_rd_data};
            4: s = m_baud;
            5: s = m_inten;
            6: s = m_ints;
            7: s = (m_rxwm << 16) | (m_txwm << 8);
            8: s = HAS_TMO ? m_tmo : 0;
            default: s = '0;
        endcase
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ctrl = 0; m_baud = 4; m_inten = 0; m_ints = 0; m_txwm = 0; m_rxwm = 1;
            m_tmo = 0; m_idle = 0; m_frm = 0; m_ovr = 0; m_txlow_prev = 0; m_rxhigh_prev = 0;
            m_txrst = 0; m_rxrst = 0; m_fired = 0;
        end else begin
            s_set = 0;
            s_ctx = (int'(tx_level) <= m_txwm);
            s_crx = (int'(rx_level) >= m_rxwm);
            if (s_ctx && !m_txlow_prev) s_set |= 1;
            if (s_crx && !m_rxhigh_prev) s_set |= 2;
            m_txlow_prev = s_ctx;
            m_rxhigh_prev = s_crx;
            if (frame_error) s_set |= 4;
            if (overrun_error) s_set |= 8;
            if (reg_wen && reg_addr == 2 && reg_wstrb[0] && !(m_ctrl[0] && !tx_full)) s_set |= 16;
            if (HAS_TMO) begin
                s_rd = reg_ren && reg_addr == 3 && m_ctrl[1] && !rx_empty;
                s_clear = rx_push || s_rd || rx_empty || !m_ctrl[1] || m_rxrst;
                if (s_clear) begin
                    m_idle = 0;
                    m_fired = 0;
                end else begin
                    if (m_tmo != 0 && m_idle >= m_tmo && !m_fired) begin
                        s_set |= 32;
                        m_fired = 1;
                    end
                    if (rx_bit_tick && m_idle < m_tmo) m_idle++;
                end
            end
            s_clr = (reg_wen && reg_addr == 6 && reg_wstrb[0]) ? int'(reg_wdata[5:0]) : 0;
            m_frm = (m_frm && !s_clr[2]) || frame_error;
            m_ovr = (m_ovr && !s_clr[3]) || overrun_error;
            m_ints = ((m_ints & ~s_clr) | s_set) & INTMASK;
            m_txrst = reg_wen && reg_addr == 7 && reg_wstrb[0] && reg_wdata[0];
            m_rxrst = reg_wen && reg_addr == 7 && reg_wstrb[0] && reg_wdata[1];
            if (reg_wen) begin
                case (int'(reg_addr))
                    0: m_ctrl = lanes(m_ctrl, reg_wdata, reg_wstrb) & 3;
                    4: begin
                        s_w = lanes(m_baud, reg_wdata, reg_wstrb) & 'hFFFF;
                        m_baud = (s_w == 0) ? 1 : s_w;
                    end
                    5: m_inten = lanes(m_inten, reg_wdata, reg_wstrb) & INTMASK;
                    7: begin
                        s_w = lanes((m_rxwm << 16) | (m_txwm << 8), reg_wdata, reg_wstrb);
                        m_txwm = (s_w >> 8) & LMASK;
                        m_rxwm = (s_w >> 16) & LMASK;
                    end
                    8: if (HAS_TMO) m_tmo = lanes(m_tmo, reg_wdata, reg_wstrb) & 'hFF;
                    default: ;
                endcase
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    bit c_wr, c_rd;
    initial begin
        forever begin
            @(negedge clk);
            c_wr = reg_wen && reg_addr == 2 && reg_wstrb[0] && m_ctrl[0] && !tx_full;
            c_rd = reg_ren && reg_addr == 3 && m_ctrl[1] && !rx_empty;
            check("irq", {31'h0, irq}, {31'h0, (m_ints & m_inten) != 0});
            check("baud_divisor", {16'h0, baud_divisor}, m_baud);
            check("baud_enable", {31'h0, baud_enable}, {31'h0, m_ctrl != 0});
            check("tx_fifo_reset", {31'h0, tx_fifo_reset}, {31'h0, m_txrst});
            check("rx_fifo_reset", {31'h0, rx_fifo_reset}, {31'h0, m_rxrst});
            check("tx_wr_en", {31'h0, tx_wr_en}, {31'h0, c_wr});
            if (c_wr) check("tx_wr_data", {24'h0, tx_wr_data}, {24'h0, reg_wdata[7:0]});
            check("rx_rd_en", {31'h0, rx_rd_en}, {31'h0, c_rd});
            check("reg_error", {31'h0, reg_error}, {31'h0, (reg_wen || reg_ren) && reg_addr > 8});
            if (reg_ren) check("reg_rdata", reg_rdata, model_read(int'(reg_addr)));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] s);
        reg_addr = AW'(a); reg_wdata = d; reg_wstrb = s; reg_wen = 1'b1;
        @(posedge clk);
        #1;
        reg_wen = 1'b0; reg_wstrb = '0;
    endtask

    task automatic rd(input int a, output logic [31:0] d, output logic e);
        reg_addr = AW'(a); reg_ren = 1'b1;
        @(negedge clk);
        d = reg_rdata;
        e = reg_error;
        @(posedge clk);
        #1;
        reg_ren = 1'b0;
    endtask

    task automatic tick_pair();
        rx_bit_tick = 1'b1;
        step(1);
        rx_bit_tick = 1'b0;
        step(1);
    endtask

    logic [31:0] d;
    logic        e;

    initial begin
        // Reset state.
        @(negedge clk);
        check("reset irq", {31'h0, irq}, 32'h0);
        check("reset baud", {16'h0, baud_divisor}, 32'h4);
        check("reset tx_fifo_reset", {31'h0, tx_fifo_reset}, 32'h0);
        #2 rst_n = 1'b1;

        // One edge after reset the TX low-watermark edge is captured.
        rd(6, d, e);  check("int_status after reset", d, 32'h1);
        rd(4, d, e);  check("baud_div reset", d, 32'h4);
        rd(7, d, e);  check("fifo_ctrl reset", d, 32'h0001_0000);
        check("irq after reset", {31'h0, irq}, 32'h0);

        // Baud divisor lane writes and zero substitution.
        wr(4, 32'h0000_0000, 4'h3);
        rd(4, d, e);  check("baud zero->1", d, 32'h1);
        wr(4, 32'h0000_1234, 4'h2);
        rd(4, d, e);  check("baud lane1", d, 32'h1201);

        // TX drop while full.
        wr(0, 32'h1, 4'h1);
        tx_full = 1'b1;
        reg_addr = 2; reg_wdata = 32'h55; reg_wstrb = 4'h1; reg_wen = 1'b1;
        @(negedge clk);
        check("tx_wr_en while full", {31'h0, tx_wr_en}, 32'h0);
        @(posedge clk);
        #1 reg_wen = 1'b0; reg_wstrb = '0; tx_full = 1'b0;
        rd(6, d, e);  check("tx_drop status", d, 32'h11);

        // Accepted TX push.
        reg_addr = 2; reg_wdata = 32'hA3; reg_wstrb = 4'h1; reg_wen = 1'b1;
        @(negedge clk);
        check("tx_wr_en accepted", {31'h0, tx_wr_en}, 32'h1);
        check("tx_wr_data", {24'h0, tx_wr_data}, 32'hA3);
        @(posedge clk);
        #1 reg_wen = 1'b0; reg_wstrb = '0;

        // irq follows enable and W1C.
        wr(5, 32'h10, 4'h1);
        @(negedge clk);
        check("irq enabled drop", {31'h0, irq}, 32'h1);
        step(1);
        wr(6, 32'h10, 4'h1);
        @(negedge clk);
        check("irq after w1c", {31'h0, irq}, 32'h0);
        step(1);

        // RX high watermark edge detection.
        wr(7, 32'h0004_0000, 4'h4);
        rx_level = 3; step(1);
        rx_level = 4; step(1);
        rd(6, d, e);  check("rx_high first", d & 32'h2, 32'h2);
        wr(6, 32'h2, 4'h1);
        step(1);
        rd(6, d, e);  check("rx_high held cleared", d & 32'h2, 32'h0);
        rx_level = 3; step(1);
        rx_level = 4; step(1);
        rd(6, d, e);  check("rx_high second", d & 32'h2, 32'h2);

        // Set wins over same-cycle W1C.
        reg_addr = 6; reg_wdata = 32'h4; reg_wstrb = 4'h1; reg_wen = 1'b1; frame_error = 1'b1;
        step(1);
        reg_wen = 1'b0; reg_wstrb = '0; frame_error = 1'b0;
        rd(6, d, e);  check("frame set wins", d & 32'h4, 32'h4);
        rd(1, d, e);  check("frame sticky", d & 32'h40, 32'h40);
        wr(6, 32'h4, 4'h1);
        rd(1, d, e);  check("frame sticky cleared", d & 32'h40, 32'h0);
        overrun_error = 1'b1; step(1); overrun_error = 1'b0;
        rd(1, d, e);  check("overrun sticky", d & 32'h80, 32'h80);

        // FIFO reset pulses one cycle after the write; WM fields untouched by lane 0.
        wr(7, 32'h3, 4'h1);
        @(negedge clk);
        check("tx_fifo_reset pulse", {31'h0, tx_fifo_reset}, 32'h1);
        check("rx_fifo_reset pulse", {31'h0, rx_fifo_reset}, 32'h1);
        step(1);
        @(negedge clk);
        check("tx_fifo_reset done", {31'h0, tx_fifo_reset}, 32'h0);
        step(1);
        rd(7, d, e);  check("fifo_ctrl wm kept", d, 32'h0004_0000);

        // Unmapped index and index 8.
        rd(9, d, e);
        check("unmapped error", {31'h0, e}, 32'h1);
        check("unmapped rdata", d, 32'h0);
        rd(8, d, e);  check("idx8 no error", {31'h0, e}, 32'h0);
`ifndef UART_RX_TIMEOUT_EN
        check("idx8 reads 0", d, 32'h0);
`endif

        // RX data pop.
        wr(0, 32'h3, 4'h1);
        rx_empty = 1'b0; rx_rd_data = 8'hA5;
        rd(3, d, e);  check("rx_data", d, 32'hA5);

`ifdef UART_RX_TIMEOUT_EN
        // Character timeout.
        wr(8, 32'h3, 4'h1);
        rd(8, d, e);  check("rx_timeout reg", d, 32'h3);
        wr(6, 32'h3F, 4'h1);
        tick_pair(); tick_pair(); tick_pair();
        rd(6, d, e);  check("timeout fired", d & 32'h20, 32'h20);
        rx_push = 1'b1; step(1); rx_push = 1'b0;
        wr(6, 32'h20, 4'h1);
        tick_pair(); tick_pair();
        rd(6, d, e);  check("timeout restarted", d & 32'h20, 32'h0);
        tick_pair();
        rd(6, d, e);  check("timeout fired again", d & 32'h20, 32'h20);
`endif

        rx_empty = 1'b1;
        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
